// File: rtl/siso_frame_pkg.sv
// Shared types and constants for the framed serial receiver.
// Frame on the wire (enabled bits only): start(1), D0..D(W-1), even parity, stop(0).
package siso_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

    // Bits needed to index 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sipo_capture_reg.sv
// Right-shift capture register: new bit enters at the MSB, so the first bit lands at bit 0.
// Single-cycle update; shift and clear are both gated by the caller.
module sipo_capture_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (clr_i) begin
            shreg_d = '0;
        end else if (shift_en_i) begin
            shreg_d = {bit_i, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign data_o = shreg_q;

endmodule

// File: rtl/siso_frame_receiver.sv
// Framed serial receiver behind the SISO shift register: start/data/parity/stop, valid/ack output.
// Every frame is committed; a commit while an unacknowledged word is held is dropped and sets Overrun.
module siso_frame_receiver
    import siso_frame_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Serial_IN,
    input  logic             Bit_EN,
    input  logic             Data_Ack,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             Data_Valid,
    output logic             Parity_Err,
    output logic             Frame_Err,
    output logic             Overrun,
    output logic             Busy
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_acc_q, par_acc_d;
    logic             par_err_q, par_err_d;

    logic             cap_clr;
    logic             cap_shift;
    logic             commit;
    logic [WIDTH-1:0] cap_data;

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             perr_q;
    logic             ferr_q;
    logic             ovr_q;
    logic             busy_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
        end
    end

    // Next-state logic; nothing moves on edges without Bit_EN
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        if (Bit_EN) begin
            case (state_q)
                IDLE: begin
                    if (Serial_IN == START_BIT) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        par_acc_d = 1'b0;
                    end
                end
                DATA: begin
                    par_acc_d = par_acc_q ^ Serial_IN;
                    if (cnt_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    par_err_d = par_acc_q ^ Serial_IN;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath controls decoded from the current state
    always_comb begin
        cap_clr   = 1'b0;
        cap_shift = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE:    cap_clr   = Bit_EN && (Serial_IN == START_BIT);
            DATA:    cap_shift = Bit_EN;
            STOP:    commit    = Bit_EN;
            default: ;
        endcase
    end

    sipo_capture_reg #(
        .WIDTH(WIDTH)
    ) u_capture (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_i      (cap_clr),
        .shift_en_i (cap_shift),
        .bit_i      (Serial_IN),
        .data_o     (cap_data)
    );

    // An ack on the commit edge frees the holding register for the new word
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            if (commit && (!valid_q || Data_Ack)) begin
                data_q  <= cap_data;
                perr_q  <= par_err_q;
                ferr_q  <= (Serial_IN != STOP_BIT);
                valid_q <= 1'b1;
            end else if (commit) begin
                ovr_q <= 1'b1;
            end else if (Data_Ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Data_OUT   = data_q;
    assign Data_Valid = valid_q;
    assign Parity_Err = perr_q;
    assign Frame_Err  = ferr_q;
    assign Overrun    = ovr_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_siso_frame_receiver.sv
// Directed and randomized frames against a frame-level reference model of the receiver.
// Inputs change and outputs are sampled on the falling edge.
module tb_siso_frame_receiver;

    logic       CLK;
    logic       RST;
    logic       Serial_IN;
    logic       Bit_EN;
    logic       Data_Ack;
    logic [3:0] Data_OUT;
    logic       Data_Valid;
    logic       Parity_Err;
    logic       Frame_Err;
    logic       Overrun;
    logic       Busy;

    int n_assert;
    int n_fail;

    logic       exp_valid;
    logic [3:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_ovr;

    siso_frame_receiver #(.WIDTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Serial_IN  (Serial_IN),
        .Bit_EN     (Bit_EN),
        .Data_Ack   (Data_Ack),
        .Data_OUT   (Data_OUT),
        .Data_Valid (Data_Valid),
        .Parity_Err (Parity_Err),
        .Frame_Err  (Frame_Err),
        .Overrun    (Overrun),
        .Busy       (Busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, return at the following falling edge.
    task automatic drive(input logic ser, input logic en, input logic ack);
        Serial_IN = ser;
        Bit_EN    = en;
        Data_Ack  = ack;
        @(negedge CLK);
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = 4'h0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy);
        check({tag, ".valid"},   Data_Valid, exp_valid);
        check({tag, ".data"},    Data_OUT,   exp_data);
        check({tag, ".overrun"}, Overrun,    exp_ovr);
        check({tag, ".busy"},    Busy,       exp_busy);
        if (exp_valid) begin
            check({tag, ".perr"}, Parity_Err, exp_perr);
            check({tag, ".ferr"}, Frame_Err,  exp_ferr);
        end
    endtask

    task automatic do_reset(input int cycles);
        RST = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            drive(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        model_reset();
        check("rst.valid", Data_Valid, 1'b0);
        check("rst.data",  Data_OUT,   4'h0);
        check("rst.perr",  Parity_Err, 1'b0);
        check("rst.ferr",  Frame_Err,  1'b0);
        check("rst.ovr",   Overrun,    1'b0);
        check("rst.busy",  Busy,       1'b0);
        RST = 1'b0;
    endtask

    task automatic ack_cycle();
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        exp_valid = 1'b0;
        check("ack.valid", Data_Valid, exp_valid);
    endtask

    // gap < 0: random 0..2 disabled cycles before each frame bit
    task automatic send_frame(input string tag, input logic [3:0] d, input logic p,
                              input logic s, input logic ack_stop, input int gap);
        logic [6:0] bits;
        int         ng;
        bits = {s, p, d, 1'b1};
        for (int i = 0; i < 7; i++) begin
            ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int g = 0; g < ng; g++) begin
                drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                if (i > 0) check({tag, ".busy_hold"}, Busy, 1'b1);
            end
            drive(bits[i], 1'b1, (i == 6) ? ack_stop : 1'b0);
            if (i < 6) check({tag, ".busy"}, Busy, 1'b1);
        end
        if (!exp_valid || ack_stop) begin
            exp_valid = 1'b1;
            exp_data  = d;
            exp_perr  = (^d) ^ p;
            exp_ferr  = s;
        end else begin
            exp_ovr = 1'b1;
        end
        check_outputs(tag, 1'b0);
    endtask

    initial begin
        logic [3:0] rd;
        logic       rp;
        logic       rs;
        n_assert  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        Serial_IN = 1'b0;
        Bit_EN    = 1'b0;
        Data_Ack  = 1'b0;
        @(negedge CLK);
        do_reset(2);

        // Enabled idle zeros must not start a frame
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("idle.busy", Busy, 1'b0);
        end

        send_frame("good_b", 4'hB, 1'b1, 1'b0, 1'b0, 0);
        ack_cycle();
        send_frame("perr_b", 4'hB, 1'b0, 1'b0, 1'b0, 0);
        ack_cycle();
        send_frame("ferr_b", 4'hB, 1'b1, 1'b1, 1'b0, 0);
        ack_cycle();
        // Ack with nothing valid has no effect
        ack_cycle();
        check_outputs("ack_idle", 1'b0);

        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0);
        send_frame("toggle_2", 4'h2, 1'b0, 1'b0, 1'b0, 1);
        ack_cycle();

        send_frame("b2b_3", 4'h3, 1'b0, 1'b0, 1'b0, 0);
        send_frame("b2b_5", 4'h5, 1'b0, 1'b0, 1'b0, 0);

        do_reset(1);
        send_frame("b2b_ack_3", 4'h3, 1'b0, 1'b0, 1'b0, 0);
        send_frame("b2b_ack_5", 4'h5, 1'b0, 1'b0, 1'b1, 0);

        // Abort after two data bits
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        check("abort.busy_pre", Busy, 1'b1);
        do_reset(2);
        drive(1'b0, 1'b1, 1'b0);
        check("abort.busy_post", Busy, 1'b0);
        send_frame("after_rst_c", 4'hC, 1'b0, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            rd = 4'($urandom_range(0, 15));
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) ack_cycle();
            if (n == 20) do_reset(1);
            send_frame("rand", rd, rp, rs, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_frame_receiver.md
# siso_frame_receiver

- Framed serial receiver that sits directly downstream of the 4-bit SISO shift register.
- Consumes the register's serial output bit stream, qualified by a bit-enable.
- Detects a start bit, deserializes WIDTH data bits LSB-first, checks even parity and the stop bit.
- Presents each completed word on a parallel port with a valid/ack handshake, plus parity, framing and overrun status.

## Interface
- WIDTH, 4, number of data bits per frame (≥2)
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- Serial_IN  in  1  serial bit stream, driven by the upstream Serial_OUT
- Bit_EN  in  1  Serial_IN is sampled only on CLK edges where Bit_EN=1; integrator drives it one cycle after upstream Load
- Data_Ack  in  1  consumer accepts Data_OUT on an edge where Data_Valid=1
- Data_OUT  out  WIDTH  last committed data word
- Data_Valid  out  1  Data_OUT holds an unconsumed word
- Parity_Err  out  1  committed word failed even parity
- Frame_Err  out  1  committed word had a bad stop bit
- Overrun  out  1  sticky: a completed frame was dropped
- Busy  out  1  frame reception in progress (state ≠ IDLE)

## Operation
- Frame format, in enabled bits: start(1), D0..D(WIDTH-1), parity P, stop(0). Total WIDTH+3 enabled bits.
- State machine: IDLE → DATA → PARITY → STOP → IDLE.
- Every transition happens only on an edge with Bit_EN=1. With Bit_EN=0, all state, counter and shift contents hold.
- IDLE: an enabled Serial_IN=0 is ignored (line idle). An enabled Serial_IN=1 goes to DATA and clears the bit counter.
- DATA: each enabled bit enters the shift register MSB-side and shifts right, so D0 ends at bit 0. After the WIDTH-th bit, go to PARITY.
- PARITY: capture P, then go to STOP. Error condition: XOR(D, P)=1.
- STOP: sample the stop bit, commit the frame and return to IDLE. Frame_Err condition: stop bit ≠ 0.
- Commit always happens, whether or not errors are detected. Error flags update only on commit.
- On commit:
  - If Data_Valid=0, or Data_Ack=1 on the same edge: load Data_OUT, Parity_Err and Frame_Err; Data_Valid=1.
  - If Data_Valid=1 and Data_Ack=0: drop the new frame. Data_OUT and the flags keep the old word. Set Overrun.
- Handshake:
  - Data_Valid stays high until an edge with Data_Ack=1, then clears.
  - Data_Ack while Data_Valid=0 has no effect.
  - Parity_Err and Frame_Err are meaningful only while Data_Valid=1.
- Overrun is cleared only by RST.
- Back-to-back frames are supported: the start bit of the next frame may be enabled on the edge immediately after the STOP edge.

## Timing
- All outputs are registered.
- Reset values: Data_OUT=0, Data_Valid=0, Parity_Err=0, Frame_Err=0, Overrun=0, Busy=0, state=IDLE, counter=0.
- RST mid-frame aborts the frame. Partial data is discarded and no commit happens. RST has priority over Bit_EN and Data_Ack.
- Busy rises the cycle after the start-bit edge and falls the cycle after the stop-bit edge.
- Latency: Data_Valid rises the cycle after the edge that samples the stop bit.
- Data_Valid falls the cycle after the acknowledging edge.
- Minimum frame duration is WIDTH+3 cycles, with Bit_EN held high.

## Structure
- Package siso_frame_pkg:
  - state enum (IDLE, DATA, PARITY, STOP);
  - START_BIT=1'b1 and STOP_BIT=1'b0 constants;
  - counter width function clog2(WIDTH).
- Sub-module sipo_capture_reg (WIDTH-bit right-shift register with shift enable and synchronous clear) holds the data bits. Top level holds the FSM, counter, parity accumulator and output/handshake registers.

## Test plan
- WIDTH=4, Bit_EN=1 continuously. Stream 1,1,1,0,1,1,0 → Data_OUT=4'hB, Data_Valid=1, Parity_Err=0, Frame_Err=0, one cycle after the stop edge. Data_Ack one cycle → Data_Valid=0.
- Same frame with P=0 → Data_OUT=4'hB, Parity_Err=1. Stop bit=1 instead → Frame_Err=1, data still committed.
- Bit_EN toggled 1-0-1-0 with frame 1,0,1,0,0,0,0 → Data_OUT=4'h2. State holds during Bit_EN=0 cycles; idle zeros before the start bit are ignored.
- Two back-to-back frames (4'h3 then 4'h5) with no Ack → first word retained, Overrun=1. Repeat with Ack on the second commit edge → Data_OUT=4'h5, Data_Valid=1, Overrun=0.
- RST asserted after 2 data bits, then a full frame for 4'hC → outputs at reset values during RST, Busy=0 after it, then Data_OUT=4'hC with no errors.
